// File: rtl/vga_bar_pkg.sv
// Shared constants for the VGA bar/trace renderer.
// Holds the default 640x480 timing, the colour set, the channel-count limit
// and a helper that adds up the segments of a line or frame.
package vga_bar_pkg;

    // Default 640x480 timing, in pixels (horizontal) and lines (vertical).
    localparam int H_ACTIVE_D = 640;
    localparam int H_FP_D     = 16;
    localparam int H_SYNC_D   = 96;
    localparam int H_BP_D     = 48;
    localparam int V_ACTIVE_D = 480;
    localparam int V_FP_D     = 10;
    localparam int V_SYNC_D   = 2;
    localparam int V_BP_D     = 33;

    // The colour table below has room for this many channels.
    localparam int MAX_CH = 4;

    localparam logic [5:0] BG_COLOR   = 6'h3F;
    localparam logic [5:0] AXIS_COLOR = 6'h00;
    localparam logic [5:0] GRID_COLOR = 6'h2A;
    // Channel k colour lives at bits [k*6 +: 6].
    localparam logic [6*MAX_CH-1:0] CH_COLOR = {6'h03, 6'h0C, 6'h30, 6'h25};

    // Total length of a line (pixels) or a frame (lines).
    function automatic int total_len(input int active, input int fp,
                                     input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters and raw sync generation for the bar renderer.
// Ports:
//   clk, rst_n, pix_en  - clock, async active-low reset, pixel tick
//   hc, vc              - current pixel column / line (registered)
//   video_on            - current position lies in the visible area
//   hs_raw, vs_raw      - undelayed sync levels for the current position
//   frame_start         - high for the pix_en tick at column 0 of line V_ACTIVE
module vga_timing
    import vga_bar_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FP     = H_FP_D,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BP     = H_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FP     = V_FP_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BP     = V_BP_D,
    parameter bit SYNC_POL = 1'b0,
    parameter int HW       = 10,
    parameter int VW       = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_en,
    output logic [HW-1:0] hc,
    output logic [VW-1:0] vc,
    output logic          video_on,
    output logic          hs_raw,
    output logic          vs_raw,
    output logic          frame_start
);

    localparam int H_T = total_len(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_T = total_len(V_ACTIVE, V_FP, V_SYNC, V_BP);

    int   hx;
    int   vy;
    logic h_last;
    logic v_last;

    always_comb begin
        hx       = int'(hc);
        vy       = int'(vc);
        h_last   = (hx == H_T - 1);
        v_last   = (vy == V_T - 1);
        video_on = (hx < H_ACTIVE) && (vy < V_ACTIVE);
        hs_raw   = (hx >= H_ACTIVE + H_FP && hx < H_ACTIVE + H_FP + H_SYNC) ? SYNC_POL : ~SYNC_POL;
        vs_raw   = (vy >= V_ACTIVE + V_FP && vy < V_ACTIVE + V_FP + V_SYNC) ? SYNC_POL : ~SYNC_POL;
    end

    // frame_start is set on the tick that moves the raster onto (0, V_ACTIVE),
    // so it is high exactly while the counters sit at that position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc          <= '0;
            vc          <= '0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            frame_start <= h_last && (vy == V_ACTIVE - 1);
            if (h_last) begin
                hc <= '0;
                vc <= v_last ? '0 : vc + 1'b1;
            end else begin
                hc <= hc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_bar_graph.sv
// N-channel VGA bar/trace renderer with built-in 640x480-style timing.
// A three-stage pipeline (address, sample, colour) keeps rgb, hsync and
// vsync aligned three pix_en ticks behind the raster counters.
// Ports:
//   clk, rst_n, pix_en  - clock, async active-low reset, pixel tick
//   mode                - 0 filled bars, 1 single-pixel trace (taken at frame start)
//   addr                - column address to the synchronous-read sample buffer
//   smp_data            - samples for addr, one pix_en tick later, channel k at k*DW
//   frame_start         - one-tick pulse at the start of vblank
//   hsync, vsync, rgb   - aligned VGA outputs
// Build option: define VGA_BAR_GRID_EN to draw a 32-pixel grid under the traces.
module vga_bar_graph
    import vga_bar_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FP     = H_FP_D,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BP     = H_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FP     = V_FP_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BP     = V_BP_D,
    parameter bit SYNC_POL = 1'b0,
    parameter int X0       = 64,
    parameter int PLOT_W   = 512,
    parameter int Y0       = 449,
    parameter int PLOT_H   = 384,
    parameter int DW       = 8,
    parameter int N_CH     = 2,
    parameter int SCALE_SH = 0,
    localparam int AW      = $clog2(PLOT_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en,
    input  logic             mode,
    output logic [AW-1:0]    addr,
    input  logic [N_CH*DW-1:0] smp_data,
    output logic             frame_start,
    output logic             hsync,
    output logic             vsync,
    output logic [5:0]       rgb
);

    localparam int HW     = $clog2(total_len(H_ACTIVE, H_FP, H_SYNC, H_BP));
    localparam int VW     = $clog2(total_len(V_ACTIVE, V_FP, V_SYNC, V_BP));
    localparam int NCH    = (N_CH > MAX_CH) ? MAX_CH : N_CH;
    localparam bit SYNC_OFF = ~SYNC_POL;

    logic [HW-1:0] hc, hc_s0, hc_s1;
    logic [VW-1:0] vc, vc_s0, vc_s1;
    logic          video_on, hs_raw, vs_raw;
    logic          von_s0, von_s1, hs_s0, hs_s1, vs_s0, vs_s1;
    logic          vld_s0, vld_s1;
    logic          mode_q;
    logic          in_plot;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL(SYNC_POL), .HW(HW), .VW(VW)
    ) u_timing (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .hc(hc), .vc(vc), .video_on(video_on),
        .hs_raw(hs_raw), .vs_raw(vs_raw), .frame_start(frame_start)
    );

    always_comb begin
        in_plot = (int'(hc) >= X0) && (int'(hc) < X0 + PLOT_W);
    end

    // Stage 1 -> 2: scale and saturate each sample, then decide the colour.
    logic [DW-1:0]  smp_sh [NCH];
    int             hgt    [NCH];
    logic [NCH-1:0] hit;
    int             px, py;
    logic [5:0]     pix_color;
`ifdef VGA_BAR_GRID_EN
    int             dx, dy;
    logic           grid_on;
`endif

    always_comb begin
        px = int'(hc_s1);
        py = int'(vc_s1);
        for (int k = 0; k < NCH; k++) begin
            smp_sh[k] = smp_data[k*DW +: DW] >> SCALE_SH;
            hgt[k]    = (int'(smp_sh[k]) > PLOT_H) ? PLOT_H : int'(smp_sh[k]);
            // Trace mode lights only the top row of a non-empty bar.
            hit[k]    = mode_q ? ((py == Y0 - hgt[k]) && (hgt[k] != 0))
                               : (py >= Y0 - hgt[k]);
        end
`ifdef VGA_BAR_GRID_EN
        dx      = px - X0;
        dy      = Y0 - py;
        grid_on = (py >= Y0 - PLOT_H) &&
                  ((((dy & 31) == 0) && (dy != 0) && (dy <= PLOT_H)) ||
                   (((dx & 31) == 0) && (dx != 0)));
`endif
        pix_color = BG_COLOR;
        if (!von_s1) begin
            pix_color = 6'h00;
        end else if (py > Y0 || px < X0 - 1 || px >= X0 + PLOT_W) begin
            pix_color = BG_COLOR;
        end else if (py == Y0 || px == X0 - 1) begin
            pix_color = AXIS_COLOR;
        end else begin
            // Walk downwards so the lowest-numbered hitting channel wins.
            for (int k = NCH - 1; k >= 0; k--) begin
                if (hit[k]) pix_color = CH_COLOR[k*6 +: 6];
            end
`ifdef VGA_BAR_GRID_EN
            if (hit == '0 && grid_on) pix_color = GRID_COLOR;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr   <= '0;
            hc_s0  <= '0;
            vc_s0  <= '0;
            von_s0 <= 1'b0;
            hs_s0  <= SYNC_OFF;
            vs_s0  <= SYNC_OFF;
            vld_s0 <= 1'b0;
            hc_s1  <= '0;
            vc_s1  <= '0;
            von_s1 <= 1'b0;
            hs_s1  <= SYNC_OFF;
            vs_s1  <= SYNC_OFF;
            vld_s1 <= 1'b0;
            rgb    <= 6'h00;
            hsync  <= SYNC_OFF;
            vsync  <= SYNC_OFF;
            mode_q <= 1'b0;
        end else if (pix_en) begin
            // Stage 0: address the buffer and forward the raster position.
            addr   <= in_plot ? AW'(int'(hc) - X0) : '0;
            hc_s0  <= hc;
            vc_s0  <= vc;
            von_s0 <= video_on;
            hs_s0  <= hs_raw;
            vs_s0  <= vs_raw;
            vld_s0 <= 1'b1;
            // Stage 1: samples for hc_s1 arrive on smp_data during this stage.
            hc_s1  <= hc_s0;
            vc_s1  <= vc_s0;
            von_s1 <= von_s0;
            hs_s1  <= hs_s0;
            vs_s1  <= vs_s0;
            vld_s1 <= vld_s0;
            // Stage 2: outputs stay at reset levels until the pipe has filled.
            rgb    <= vld_s1 ? pix_color : 6'h00;
            hsync  <= vld_s1 ? hs_s1 : SYNC_OFF;
            vsync  <= vld_s1 ? vs_s1 : SYNC_OFF;
            // Mode only changes in vblank, so a frame is never drawn half and half.
            if (frame_start) mode_q <= mode;
        end
    end

endmodule

// File: doc/vga_bar_graph.md
# vga_bar_graph

Parametrised VGA bar/trace renderer for an N-channel column-sample buffer. It generates its own 640x480 sync timing and fetches one sample per channel per plot column from an external synchronous-read buffer. Channel heights are overlaid in priority order over a framed plot area; the output is 6-bit RGB with matching hsync/vsync. It sits between the sample memory and the board's VGA DAC, replacing the fixed single-channel bar display.

## Interface
- H_ACTIVE, 640, visible pixels per line; H_FP 16, H_SYNC 96, H_BP 48 in pixels
- V_ACTIVE, 480, visible lines; V_FP 10, V_SYNC 2, V_BP 33 in lines
- SYNC_POL, 0, sync active level (0 = active-low)
- X0, 64, first plot column
- PLOT_W, 512, plot columns; address width AW = $clog2(PLOT_W)
- Y0, 449, baseline (axis) row; PLOT_H, 384, maximum bar height in rows
- DW, 8, sample width; N_CH, 2, channels (1..4); SCALE_SH, 0, right shift applied to samples
- BG_COLOR 6'h3F, AXIS_COLOR 6'h00, CH_COLOR {6'h25,6'h30,6'h0C,6'h03}, colour per channel
- clk  in  1  pixel-domain system clock
- rst_n  in  1  asynchronous active-low reset
- pix_en  in  1  pixel tick; all state advances only when high
- mode  in  1  0 = filled bars, 1 = single-pixel trace; sampled at frame start
- addr  out  AW  column address to sample buffer
- smp_data  in  N_CH*DW  samples for addr, valid one pix_en tick after addr (channel k at bits k*DW +: DW)
- frame_start  out  1  one-tick pulse on first pix_en of line V_ACTIVE (start of vblank)
- hsync, vsync  out  1  syncs, aligned to rgb
- rgb  out  6  pixel colour

## Operation
- Counters hc (0..H_total-1), vc (0..V_total-1); hc wraps then vc increments; vc wraps at V_total.
- Stage 0: addr <= (hc >= X0 && hc < X0+PLOT_W) ? hc-X0 : 0; hc/vc/video_on forwarded.
- Stage 1: smp_data valid; h_k = min(smp_k >> SCALE_SH, PLOT_H), computed at DW bits, saturated.
- Stage 2: rgb registered. Priority: !video_on -> 0; vc > Y0 or hc < X0-1 or hc >= X0+PLOT_W -> BG; vc == Y0 or hc == X0-1 -> AXIS; else lowest k whose hit is true -> CH_COLOR[k]; else BG.
- hit_k: mode_q == 0 -> vc >= Y0-h_k; mode_q == 1 -> vc == Y0-h_k and h_k != 0.
- mode_q latched from mode only on frame_start; mid-frame changes never tear.
- frame_start asserted for exactly one pix_en tick per frame; lets the writer swap buffers during vblank.

## Timing
- Pipeline latency 3 pix_en ticks from counter to rgb; hsync/vsync delayed identically, so sync/rgb alignment is exact.
- Reset: hc=vc=0, addr=0, rgb=0, frame_start=0, hsync=vsync=!SYNC_POL level (inactive), mode_q=0, pipeline valid bits cleared.
- Reset deassertion: first visible pixel reaches rgb 3 ticks after the first pix_en.
- Reset mid-frame: all outputs return to reset values immediately (async); timing restarts at pixel (0,0).
- pix_en low: all registers hold, outputs stable.
- h_k == 0: no bar pixel; h_k == PLOT_H: top pixel at row Y0-PLOT_H.

## Configuration
- VGA_BAR_GRID_EN defined: rows Y0-32m (m >= 1, within PLOT_H) and columns X0+32m not hit by any channel draw in 6'h2A; priority just above BG.
- Undefined: no grid logic; behaviour exactly as above.

## Structure
- Package vga_bar_pkg: default timing constants, colour constants, channel-count limit, function for total line/frame length.
- Sub-module vga_timing: counters, raw sync, video_on, frame_start; the renderer pipeline lives in vga_bar_graph.

## Test plan
- Reset then free-run with pix_en=1: hsync period 800 ticks, low 96; vsync period 525 lines, low 2; frame_start once per 420000 ticks.
- Ch0 sample=100 at addr 10, N_CH=1, mode 0: column 74 rows 349..448 = 6'h25, row 348 = BG, row 449 = AXIS.
- Ch0=50, ch1=120 same column: rows 399..448 = 6'h25, rows 329..398 = 6'h30.
- mode toggled to 1 mid-frame: current frame still bars; next frame only row Y0-h_k coloured per channel.
- Sample 255, SCALE_SH=0, PLOT_H=200: bar clipped at row 249; sample 0 gives no channel pixel.
- Assert rst_n low mid-line: rgb=0 and syncs inactive in the same cycle; after release, timing restarts at hc=vc=0.
